// File: rtl/sum_pkg.sv
// Shared types and constants for the sum block accumulator slice.
package sum_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic {
    ACCUM      = 1'b0,
    FLUSH_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sum_out_fifo.sv
// Two-entry output FIFO. The head entry is a register that drives the consumer directly.
module sum_out_fifo
  import sum_pkg::*;
#(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [1:0]   cnt_r;
  logic [W-1:0] mem0_r;
  logic [W-1:0] mem1_r;
  logic         pop_ok_s;
  logic         push_ok_s;

  assign full      = (cnt_r == 2'(FIFO_DEPTH));
  assign empty     = (cnt_r == 2'd0);
  assign head      = mem0_r;
  assign pop_ok_s  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
  assign push_ok_s = push & (~full | pop_ok_s);

  // Entry storage and occupancy; mem0_r is always the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= 2'd0;
      mem0_r <= {W{1'b0}};
      mem1_r <= {W{1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            mem0_r <= push_data;
          end else begin
            mem1_r <= push_data;
          end
          cnt_r <= cnt_r + 2'd1;
        end
        2'b01: begin
          mem0_r <= mem1_r;
          cnt_r  <= cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd1) begin
            mem0_r <= push_data;
          end else begin
            mem0_r <= mem1_r;
            mem1_r <= push_data;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/sum_block_accum.sv
// Accumulates BLOCK_LEN adder sums per block total and queues totals in a 2-entry FIFO.
// Define SUM_ACC_SATURATE_EN to clamp overflowing totals instead of wrapping them.
module sum_block_accum
  import sum_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BLOCK_LEN = 4,
  parameter int ACC_W     = DATA_W + $clog2(BLOCK_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_partial,
  input  logic              out_ready,
  output logic              ovf
);

  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  state_t           state_r, state_nx;
  logic [ACC_W-1:0] acc_r, acc_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic             blk_ovf_r, blk_ovf_nx;
  logic             ovf_r, ovf_nx;

  logic             push_s;
  logic [ACC_W:0]   push_data_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [ACC_W:0]   fifo_head_s;
  logic             pop_s;
  logic             space_s;
  logic             last_s;
  logic             accept_s;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] sum_clip_s;
  logic             sum_ovf_s;
  logic [ACC_W-1:0] cur_total_s;
  logic             cur_ovf_s;

  assign pop_s     = ~fifo_empty_s & out_ready;
  assign space_s   = ~fifo_full_s | pop_s;
  assign last_s    = (cnt_r == LAST_CNT);
  assign in_ready  = (state_r == ACCUM) & ~(last_s & ~space_s);
  assign accept_s  = in_valid & in_ready;
  assign sum_s     = {1'b0, acc_r} + (ACC_W + 1)'(in_data);
`ifdef SUM_ACC_SATURATE_EN
  assign sum_clip_s = sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
`else
  assign sum_clip_s = sum_s[ACC_W-1:0];
`endif
  // A block overflows if any intermediate sum did, since wrapping can hide it by the end.
  assign sum_ovf_s   = sum_s[ACC_W] | blk_ovf_r;
  assign cur_total_s = accept_s ? sum_clip_s : acc_r;
  assign cur_ovf_s   = accept_s ? sum_ovf_s : blk_ovf_r;

  // Next-state and push decision for the accumulate / flush-wait FSM.
  always_comb begin
    state_nx    = state_r;
    acc_nx      = acc_r;
    cnt_nx      = cnt_r;
    blk_ovf_nx  = blk_ovf_r;
    ovf_nx      = ovf_r;
    push_s      = 1'b0;
    push_data_s = {1'b0, acc_r};
    case (state_r)
      ACCUM: begin
        if (accept_s && last_s) begin
          push_s      = 1'b1;
          push_data_s = {1'b0, sum_clip_s};
          ovf_nx      = ovf_r | sum_ovf_s;
          acc_nx      = {ACC_W{1'b0}};
          cnt_nx      = {CNT_W{1'b0}};
          blk_ovf_nx  = 1'b0;
        end else if (flush && (accept_s || (cnt_r != {CNT_W{1'b0}}))) begin
          cnt_nx = {CNT_W{1'b0}};
          if (space_s) begin
            push_s      = 1'b1;
            push_data_s = {1'b1, cur_total_s};
            ovf_nx      = ovf_r | cur_ovf_s;
            acc_nx      = {ACC_W{1'b0}};
            blk_ovf_nx  = 1'b0;
          end else begin
            acc_nx     = cur_total_s;
            blk_ovf_nx = cur_ovf_s;
            state_nx   = FLUSH_WAIT;
          end
        end else if (accept_s) begin
          acc_nx     = sum_clip_s;
          cnt_nx     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          blk_ovf_nx = sum_ovf_s;
        end else begin
          state_nx = ACCUM;
        end
      end
      FLUSH_WAIT: begin
        if (space_s) begin
          push_s      = 1'b1;
          push_data_s = {1'b1, acc_r};
          ovf_nx      = ovf_r | blk_ovf_r;
          acc_nx      = {ACC_W{1'b0}};
          cnt_nx      = {CNT_W{1'b0}};
          blk_ovf_nx  = 1'b0;
          state_nx    = ACCUM;
        end else begin
          state_nx = FLUSH_WAIT;
        end
      end
      default: begin
        state_nx = ACCUM;
      end
    endcase
  end

  // State, accumulator and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ACCUM;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      blk_ovf_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_nx;
      acc_r     <= acc_nx;
      cnt_r     <= cnt_nx;
      blk_ovf_r <= blk_ovf_nx;
      ovf_r     <= ovf_nx;
    end
  end

  sum_out_fifo #(.W(ACC_W + 1)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s)
  );

  assign out_valid   = ~fifo_empty_s;
  assign out_data    = fifo_head_s[ACC_W-1:0];
  assign out_partial = fifo_head_s[ACC_W];
  assign ovf         = ovf_r;

endmodule

// File: tb/tb_sum_block_accum.sv
// Directed bench for sum_block_accum: vector table plus hand-written stall/flush/reset sequences.
module tb_sum_block_accum;

  logic        clk;
  logic        reset;
  logic        in_valid, flush, out_ready;
  logic [11:0] in_data;
  logic        in_ready, out_valid, out_partial, ovf;
  logic [13:0] out_data;

  logic        in_valid2, flush2, out_ready2;
  logic [11:0] in_data2;
  logic        in_ready2, out_valid2, out_partial2, ovf2;
  logic [12:0] out_data2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        v;
    logic [11:0] d;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [13:0] e_od;
    logic        e_op;
    logic        e_ovf;
  } vec_t;

  vec_t        vecs[$];
  logic [13:0] got_d[$];
  logic        got_p[$];

`ifdef SUM_ACC_SATURATE_EN
  localparam logic [12:0] EXP6 = 13'd8191;
`else
  localparam logic [12:0] EXP6 = 13'd8188;
`endif

  sum_block_accum dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_partial(out_partial),
    .out_ready(out_ready), .ovf(ovf)
  );

  sum_block_accum #(.ACC_W(13)) dut13 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .flush(flush2), .out_valid(out_valid2), .out_data(out_data2), .out_partial(out_partial2),
    .out_ready(out_ready2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [11:0] d, input logic fl,
                              input logic e_ov, input logic [13:0] e_od, input logic e_op);
    vec_t r;
    r.v = v; r.d = d; r.fl = fl; r.ordy = 1'b1; r.e_ir = 1'b1;
    r.e_ov = e_ov; r.e_od = e_od; r.e_op = e_op; r.e_ovf = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run ncyc cycles with out_ready high, logging every popped head.
  task automatic collect(input int ncyc);
    out_ready = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (out_valid) begin
        got_d.push_back(out_data);
        got_p.push_back(out_partial);
      end
      tick();
    end
  endtask

  task automatic check_pops(input string nm, input int n, input logic [13:0] d0,
                            input logic [13:0] d1, input logic [13:0] d2, input logic [2:0] p);
    logic [13:0] ed[3];
    ed[0] = d0; ed[1] = d1; ed[2] = d2;
    chk({nm, " pop count"}, got_d.size(), n);
    for (int k = 0; k < n && k < got_d.size(); k++) begin
      chk($sformatf("%s pop%0d data", nm, k), got_d[k], ed[k]);
      chk($sformatf("%s pop%0d partial", nm, k), got_p[k], p[k]);
    end
    got_d.delete();
    got_p.delete();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 12'd0; flush = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = 12'd0; flush2 = 1'b0; out_ready2 = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_partial", out_partial, 0);
    chk("reset ovf", ovf, 0);
    tick();

    // Outputs in a row are what the DUT shows during that row's cycle.
    vecs.push_back(mk(1, 12'd100, 0, 0, 14'd0, 0));
    vecs.push_back(mk(1, 12'd200, 0, 0, 14'd0, 0));
    vecs.push_back(mk(1, 12'd300, 0, 0, 14'd0, 0));
    vecs.push_back(mk(1, 12'd400, 0, 0, 14'd0, 0));
    vecs.push_back(mk(0, 12'd0, 0, 1, 14'd1000, 0));
    vecs.push_back(mk(0, 12'd0, 0, 0, 14'd0, 0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 12'd4095, 0, 0, 14'd0, 0));
    vecs.push_back(mk(0, 12'd0, 0, 1, 14'd16380, 0));
    vecs.push_back(mk(0, 12'd0, 0, 0, 14'd0, 0));
    vecs.push_back(mk(1, 12'd10, 0, 0, 14'd0, 0));
    vecs.push_back(mk(1, 12'd20, 0, 0, 14'd0, 0));
    vecs.push_back(mk(0, 12'd0, 1, 0, 14'd0, 0));
    vecs.push_back(mk(0, 12'd0, 0, 1, 14'd30, 1));
    vecs.push_back(mk(0, 12'd0, 1, 0, 14'd0, 0));
    vecs.push_back(mk(0, 12'd0, 0, 0, 14'd0, 0));
    vecs.push_back(mk(1, 12'd1, 0, 0, 14'd0, 0));
    vecs.push_back(mk(1, 12'd2, 0, 0, 14'd0, 0));
    vecs.push_back(mk(1, 12'd3, 0, 0, 14'd0, 0));
    vecs.push_back(mk(1, 12'd4, 1, 0, 14'd0, 0));
    vecs.push_back(mk(0, 12'd0, 0, 1, 14'd10, 0));
    vecs.push_back(mk(0, 12'd0, 0, 0, 14'd0, 0));
    vecs.push_back(mk(1, 12'd5, 0, 0, 14'd0, 0));
    vecs.push_back(mk(1, 12'd6, 1, 0, 14'd0, 0));
    vecs.push_back(mk(0, 12'd0, 0, 1, 14'd11, 1));
    vecs.push_back(mk(0, 12'd0, 0, 0, 14'd0, 0));

    foreach (vecs[i]) begin
      in_valid = vecs[i].v; in_data = vecs[i].d; flush = vecs[i].fl; out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ir);
      chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d out_data", i), out_data, vecs[i].e_od);
        chk($sformatf("vec%0d out_partial", i), out_partial, vecs[i].e_op);
      end
      chk($sformatf("vec%0d ovf", i), ovf, vecs[i].e_ovf);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;

    // Full FIFO stalls the 12th sample; releasing out_ready lets it through in the same cycle.
    out_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      in_valid = 1'b1; in_data = 12'd1;
      @(negedge clk);
      chk($sformatf("stall acc%0d in_ready", k), in_ready, 1);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall in_ready", in_ready, 0);
      chk("stall out_valid", out_valid, 1);
      chk("stall out_data", out_data, 4);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release in_ready", in_ready, 1);
    if (out_valid) begin
      got_d.push_back(out_data);
      got_p.push_back(out_partial);
    end
    tick();
    in_valid = 1'b0;
    collect(6);
    check_pops("stall", 3, 14'd4, 14'd4, 14'd4, 3'b000);

    // Flush while the FIFO is full parks the partial total in FLUSH_WAIT.
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = (k < 8) ? 12'd1 : 12'(k - 6);
      tick();
    end
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fw flush cycle in_ready", in_ready, 1);
    tick();
    in_valid = 1'b1; in_data = 12'd100; flush = 1'b1;
    @(negedge clk);
    chk("fw wait in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fw wait2 in_ready", in_ready, 0);
    tick();
    collect(6);
    check_pops("flushwait", 3, 14'd4, 14'd4, 14'd5, 3'b100);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("fw after empty flush out_valid", out_valid, 0);
      tick();
    end

    // Reset mid-block discards the 7,7 partial sum.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 12'd7;
      tick();
    end
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1);
    chk("post-reset out_valid", out_valid, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 12'd1;
      tick();
    end
    in_valid = 1'b0;
    collect(4);
    check_pops("reset", 1, 14'd4, 14'd0, 14'd0, 3'b000);
    @(negedge clk);
    chk("reset ovf", ovf, 0);
    tick();

    // Narrow accumulator overflow.
    for (int k = 0; k < 4; k++) begin
      in_valid2 = 1'b1; in_data2 = 12'd4095;
      tick();
    end
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("acc13 in_ready", in_ready2, 1);
    chk("acc13 out_valid", out_valid2, 1);
    chk("acc13 out_data", out_data2, EXP6);
    chk("acc13 out_partial", out_partial2, 0);
    chk("acc13 ovf", ovf2, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
